fp_div_iter: RTL and testbench
==============================

Name: fp_div_iter

Overview:
Parametrised, sequential IEEE-754 floating-point divider core that succeeds the fixed double-precision divider. It is generic in exponent and fraction width, and uses a valid/ready handshake with output back-pressure, exception flags and round-to-nearest-even. It computes one quotient bit per clock with a radix-2 restoring iteration. It sits behind the debug/top wrappers, with the VIO or an upstream root-finding controller driving operands.

Parameters:
EXP_W, 11, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 52, stored fraction width (hidden bit implicit); total word W = 1+EXP_W+MAN_W

Ports:
clk  input  1  single clock, all state on rising edge
rset  input  1  asynchronous, active-high reset
in_valid  input  1  operands presented
in_ready  output  1  core can accept operands
dividend  input  W  IEEE operand a
divisor  input  W  IEEE operand b
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
quotient  output  W  a/b, RNE
flags  output  4  {invalid, div_by_zero, overflow, underflow}

Behaviour:
- Reset (async): state=IDLE; quotient=0, flags=0, out_valid=0, in_ready=0 while rset high, all datapath regs 0. Reset mid-operation aborts silently; no output is produced for the aborted operation.
- States: IDLE -> UNPACK -> DIVIDE -> ROUND -> DONE -> IDLE. UNPACK -> DONE directly for special operands.
- in_ready = (state==IDLE) and not rset. Accept on in_valid&in_ready (edge 0). Operands are registered at edge 0; later input changes are ignored.
- Subnormal inputs are treated as signed zero (DAZ). Tiny results flush to signed zero (FTZ).
- Sign = sa XOR sb for every result, including zero and inf. NaN results have sign 0.
- Specials (UNPACK, priority order):
  - either NaN -> qNaN (exp all ones, frac MSB=1, rest 0).
  - 0/0 or inf/inf -> qNaN, invalid=1.
  - inf/x -> inf.
  - finite nonzero/0 -> inf, div_by_zero=1.
  - x/inf -> 0.
  - 0/x -> 0.
- Normal path: ma, mb = {1,frac} (MAN_W+1 bits). e = ea - eb + bias, signed EXP_W+2 bits. DIVIDE runs exactly MAN_W+3 iterations with a counter: rem = rem - mb if rem >= mb (qbit=1), then rem <<= 1. This yields Q[MAN_W+2:0] with weight 2^0 .. 2^-(MAN_W+2).
- ROUND:
  - If Q[MAN_W+2]=1: mant = Q[MAN_W+2:2], guard = Q[1], sticky = Q[0] | (rem != 0).
  - Else: mant = Q[MAN_W+1:1], guard = Q[0], sticky = (rem != 0), e = e-1.
  - RNE: increment when guard & (sticky | mant[0]). A carry-out renormalises (mant >>= 1, e+1).
  - e >= 2^EXP_W-1 -> inf, overflow=1.
  - e <= 0 -> signed zero, underflow=1.
- Latency from accept edge 0: special -> out_valid after edge 1; normal -> out_valid after edge MAN_W+5 (57 for double). The latency is fixed and does not depend on the data.
- DONE: quotient/flags held stable while out_valid=1 and out_ready=0 (indefinitely). Transition to IDLE on out_valid&out_ready. out_valid drops on the same edge. The next accept is possible at the following edge at the earliest, so throughput is 1 op per MAN_W+7 cycles.
- flags are cleared at each accept. More than one flag bit can be set only if two conditions coexist, which by construction cannot occur.

Decomposition:
- Package fp_div_pkg: state encoding localparams, flag bit indices (FLG_INV=3, FLG_DZ=2, FLG_OF=1, FLG_UF=0), bias/width helper functions, and qNaN/inf constructor functions parametrised by EXP_W/MAN_W.
- One sub-module, fp_div_round_pack: combinational normalise/RNE/overflow-underflow/pack from {sign, e, Q, rem != 0}. It is unit-testable in isolation.

Test Plan:
- 6.0/2.0: 0x4018000000000000 / 0x4000000000000000 -> 0x4008000000000000, flags=0, out_valid after exactly edge 57.
- 1/3: 0x3FF0000000000000 / 0x4008000000000000 -> 0x3FD5555555555555 (RNE rounds down); -1/3 (0xBFF0000000000000 dividend) -> 0xBFD5555555555555.
- Specials:
  - 1.0/+0 -> 0x7FF0000000000000, flags=0100, latency 1.
  - 0/0 -> 0x7FF8000000000000, flags=1000.
  - -0/5.0 -> 0x8000000000000000.
- Range: 0x7FEFFFFFFFFFFFFF / 0x3FE0000000000000 -> 0x7FF0000000000000, flags=0010. 0x0010000000000000 / 0x4000000000000000 -> 0x0000000000000000, flags=0001.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid. quotient/flags stable, in_ready=0 throughout, and a new in_valid is ignored until the handshake completes.
- Reset mid-DIVIDE: assert rset at cycle 20 of a 6.0/2.0 operation -> out_valid=0, quotient=0 immediately. After release, in_ready=1 and a fresh 1/3 completes correctly.

Source files
------------

// File: rtl/fp_div_pkg.sv
// Shared definitions for the iterative floating-point divider: FSM state
// encoding, flag bit positions and helpers that build width-generic
// IEEE-754 constants (bias, infinity and quiet-NaN bit patterns).
package fp_div_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_UNPACK = 3'd1;
   localparam logic [2:0] ST_DIVIDE = 3'd2;
   localparam logic [2:0] ST_ROUND  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam int FLG_INV = 3;
   localparam int FLG_DZ  = 2;
   localparam int FLG_OF  = 1;
   localparam int FLG_UF  = 0;

   // Widest word the constructor functions can describe; callers slice down.
   localparam int MAX_W = 128;

   // Total IEEE word width for a given exponent/fraction split.
   function automatic int wordWidth(input int expW, input int manW);
      return 1 + expW + manW;
   endfunction

   // Exponent bias, 2^(expW-1)-1.
   function automatic int expBias(input int expW);
      return (1 << (expW - 1)) - 1;
   endfunction

   // Unsigned infinity pattern: exponent all ones, fraction zero.
   function automatic logic [MAX_W-1:0] infMag(input int expW, input int manW);
      logic [MAX_W-1:0] one;
      one = {{(MAX_W-1){1'b0}}, 1'b1};
      return ((one << expW) - one) << manW;
   endfunction

   // Canonical quiet NaN: exponent all ones, only the fraction MSB set.
   function automatic logic [MAX_W-1:0] qnanMag(input int expW, input int manW);
      logic [MAX_W-1:0] one;
      one = {{(MAX_W-1){1'b0}}, 1'b1};
      return infMag(expW, manW) | (one << (manW - 1));
   endfunction

endpackage

// File: rtl/fp_div_round_pack.sv
// Combinational back end of the divider: takes the raw quotient bits,
// the biased exponent estimate and the remainder-nonzero indication,
// normalises by at most one position, rounds to nearest-even and packs
// the IEEE word, clamping to infinity or flushing to zero when out of range.
module fp_div_round_pack
   import fp_div_pkg::*;
#(
   parameter int EXP_W = 11,
   parameter int MAN_W = 52
)
(
   input  logic                      sign_i,
   input  logic signed [EXP_W+1:0]   exp_i,
   input  logic [MAN_W+2:0]          quo_i,
   input  logic                      remNz_i,
   output logic [EXP_W+MAN_W:0]      word_o,
   output logic                      overflow_o,
   output logic                      underflow_o
);

   localparam int EW = EXP_W + 2;
   localparam logic [MAX_W-1:0] INF_WIDE = infMag(EXP_W, MAN_W);
   localparam logic [EXP_W+MAN_W-1:0] INF_MAG = INF_WIDE[EXP_W+MAN_W-1:0];
   localparam logic signed [EW-1:0] ONE_E   = EW'(1);
   localparam logic signed [EW-1:0] ZERO_E  = EW'(0);
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

   logic [MAN_W:0]          mant;
   logic                    guard;
   logic                    sticky;
   logic signed [EW-1:0]    eNorm;
   logic signed [EW-1:0]    eFin;
   logic                    roundUp;
   logic [MAN_W+1:0]        mantSum;
   logic [MAN_W-1:0]        fracFin;

   // Normalise (quotient lies in (1/2, 2)), round to nearest-even, then
   // range-check the final exponent and assemble the packed result.
   always_comb begin
      if (quo_i[MAN_W+2]) begin
         mant   = quo_i[MAN_W+2:2];
         guard  = quo_i[1];
         sticky = quo_i[0] | remNz_i;
         eNorm  = exp_i;
      end else begin
         mant   = quo_i[MAN_W+1:1];
         guard  = quo_i[0];
         sticky = remNz_i;
         eNorm  = exp_i - ONE_E;
      end

      roundUp = guard & (sticky | mant[0]);
      mantSum = {1'b0, mant} + {{(MAN_W+1){1'b0}}, roundUp};

      // A carry out only happens from an all-ones mantissa, so the
      // renormalised value is 1.000... and the dropped LSB is zero.
      if (mantSum[MAN_W+1]) begin
         fracFin = mantSum[MAN_W:1];
         eFin    = eNorm + ONE_E;
      end else begin
         fracFin = mantSum[MAN_W-1:0];
         eFin    = eNorm;
      end

      overflow_o  = (eFin >= EXP_MAX);
      underflow_o = !overflow_o && (eFin <= ZERO_E);

      if (overflow_o) begin
         word_o = {sign_i, INF_MAG};
      end else if (underflow_o) begin
         word_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      end else begin
         word_o = {sign_i, eFin[EXP_W-1:0], fracFin};
      end
   end

endmodule

// File: rtl/fp_div_iter.sv
// Sequential IEEE-754 divider, generic in exponent/fraction width.
// Operands are captured on a valid/ready handshake, special operands are
// resolved in one cycle, and finite operands go through a radix-2
// restoring division producing one quotient bit per clock before a
// single rounding/packing cycle. Results are held under back-pressure.
module fp_div_iter
   import fp_div_pkg::*;
#(
   parameter int EXP_W = 11,
   parameter int MAN_W = 52
)
(
   input  logic                  clk,
   input  logic                  rset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [EXP_W+MAN_W:0]  dividend,
   input  logic [EXP_W+MAN_W:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [EXP_W+MAN_W:0]  quotient,
   output logic [3:0]            flags
);

   localparam int W     = wordWidth(EXP_W, MAN_W);
   localparam int EW    = EXP_W + 2;
   localparam int CNT_W = $clog2(MAN_W + 3);

   localparam logic [MAX_W-1:0] INF_WIDE  = infMag(EXP_W, MAN_W);
   localparam logic [MAX_W-1:0] QNAN_WIDE = qnanMag(EXP_W, MAN_W);
   localparam logic [W-1:0]     QNAN_WORD = {1'b0, QNAN_WIDE[W-2:0]};
   localparam logic [W-2:0]     INF_MAG   = INF_WIDE[W-2:0];
   localparam logic [W-2:0]     ZERO_MAG  = '0;
   localparam logic [EW-1:0]    BIAS_E    = EW'(expBias(EXP_W));
   localparam logic [EXP_W-1:0] EXP_ONES  = '1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MAN_W + 2);

   logic [2:0]         state_q,    state_d;
   logic [W-1:0]       opA_q,      opA_d;
   logic [W-1:0]       opB_q,      opB_d;
   logic               sign_q,     sign_d;
   logic [EW-1:0]      exp_q,      exp_d;
   logic [MAN_W:0]     mb_q,       mb_d;
   logic [MAN_W+1:0]   rem_q,      rem_d;
   logic [MAN_W+2:0]   quo_q,      quo_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic [W-1:0]       result_q,   result_d;
   logic [3:0]         flags_q,    flags_d;
   logic               outValid_q, outValid_d;

   logic               signA, signB;
   logic [EXP_W-1:0]   expA, expB;
   logic [MAN_W-1:0]   fracA, fracB;
   logic               aZero, bZero, aInf, bInf, aNan, bNan;
   logic               signQ;

   logic [MAN_W+1:0]   mbExt;
   logic               remGeq;
   logic [MAN_W+1:0]   remSub;
   logic [MAN_W+1:0]   remSel;

   logic               remNz;
   logic [W-1:0]       rpWord;
   logic               rpOvf;
   logic               rpUnf;

   assign {signA, expA, fracA} = opA_q;
   assign {signB, expB, fracB} = opB_q;

   // Subnormal operands count as zero, so a zero exponent alone means zero.
   assign aZero = (expA == '0);
   assign bZero = (expB == '0);
   assign aInf  = (expA == EXP_ONES) && (fracA == '0);
   assign bInf  = (expB == EXP_ONES) && (fracB == '0);
   assign aNan  = (expA == EXP_ONES) && (fracA != '0);
   assign bNan  = (expB == EXP_ONES) && (fracB != '0);
   assign signQ = signA ^ signB;

   assign mbExt  = {1'b0, mb_q};
   assign remGeq = (rem_q >= mbExt);
   assign remSub = rem_q - mbExt;
   assign remSel = remGeq ? remSub : rem_q;
   assign remNz  = (rem_q != '0);

   assign in_ready  = (state_q == ST_IDLE) && !rset;
   assign out_valid = outValid_q;
   assign quotient  = result_q;
   assign flags     = flags_q;

   fp_div_round_pack #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) uRoundPack (
      .sign_i      (sign_q),
      .exp_i       (exp_q),
      .quo_i       (quo_q),
      .remNz_i     (remNz),
      .word_o      (rpWord),
      .overflow_o  (rpOvf),
      .underflow_o (rpUnf)
   );

   // Next-state logic: handshake capture, special-case resolution, one
   // restoring-division step per DIVIDE cycle, and result hand-off.
   always_comb begin
      state_d    = state_q;
      opA_d      = opA_q;
      opB_d      = opB_q;
      sign_d     = sign_q;
      exp_d      = exp_q;
      mb_d       = mb_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      flags_d    = flags_q;
      outValid_d = outValid_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               opA_d   = dividend;
               opB_d   = divisor;
               flags_d = '0;
               state_d = ST_UNPACK;
            end
         end

         ST_UNPACK: begin
            sign_d     = signQ;
            outValid_d = 1'b1;
            state_d    = ST_DONE;
            if (aNan || bNan) begin
               result_d = QNAN_WORD;
            end else if ((aZero && bZero) || (aInf && bInf)) begin
               result_d         = QNAN_WORD;
               flags_d[FLG_INV] = 1'b1;
            end else if (aInf) begin
               result_d = {signQ, INF_MAG};
            end else if (bZero) begin
               result_d        = {signQ, INF_MAG};
               flags_d[FLG_DZ] = 1'b1;
            end else if (bInf || aZero) begin
               result_d = {signQ, ZERO_MAG};
            end else begin
               outValid_d = 1'b0;
               state_d    = ST_DIVIDE;
               exp_d      = {2'b00, expA} - {2'b00, expB} + BIAS_E;
               mb_d       = {1'b1, fracB};
               rem_d      = {1'b0, 1'b1, fracA};
               quo_d      = '0;
               cnt_d      = '0;
            end
         end

         ST_DIVIDE: begin
            rem_d = remSel << 1;
            quo_d = {quo_q[MAN_W+1:0], remGeq};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d = ST_ROUND;
            end
         end

         ST_ROUND: begin
            result_d        = rpWord;
            flags_d[FLG_OF] = rpOvf;
            flags_d[FLG_UF] = rpUnf;
            outValid_d      = 1'b1;
            state_d         = ST_DONE;
         end

         ST_DONE: begin
            if (out_ready) begin
               outValid_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end

         default: begin
            state_d    = ST_IDLE;
            outValid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk or posedge rset) begin
      if (rset) begin
         state_q    <= ST_IDLE;
         opA_q      <= '0;
         opB_q      <= '0;
         sign_q     <= 1'b0;
         exp_q      <= '0;
         mb_q       <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         flags_q    <= '0;
         outValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         opA_q      <= opA_d;
         opB_q      <= opB_d;
         sign_q     <= sign_d;
         exp_q      <= exp_d;
         mb_q       <= mb_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         flags_q    <= flags_d;
         outValid_q <= outValid_d;
      end
   end

endmodule

// File: tb/tb_fp_div_iter.sv
// Scoreboard testbench for the double-precision configuration of
// fp_div_iter: directed and random operands, an integer-arithmetic
// reference model, output back-pressure and reset during a division.
module tb_fp_div_iter;

   localparam int EXP_W       = 11;
   localparam int MAN_W       = 52;
   localparam int W           = 64;
   localparam int LAT_SPECIAL = 1;
   localparam int LAT_NORMAL  = 57;
   localparam int NUM_DIR     = 13;
   localparam int NUM_RAND    = 40;

   typedef struct {
      logic [63:0] q;
      logic [3:0]  f;
      int          lat;
      int          acc;
   } expT;

   logic          clk       = 1'b0;
   logic          rset      = 1'b1;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [W-1:0]  dividend  = '0;
   logic [W-1:0]  divisor   = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  quotient;
   logic [3:0]    flags;

   expT           scoreQ[$];
   int            checks    = 0;
   int            errors    = 0;
   int            cycleCnt  = 0;
   int            readyMode = 0;
   logic          holding   = 1'b0;
   logic [63:0]   heldQ     = '0;
   logic [3:0]    heldF     = '0;

   logic [63:0]   dirA[NUM_DIR];
   logic [63:0]   dirB[NUM_DIR];
   logic [63:0]   dirQ[NUM_DIR];
   logic [3:0]    dirF[NUM_DIR];
   int            dirL[NUM_DIR];

   fp_div_iter #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) dut (
      .clk       (clk),
      .rset      (rset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .flags     (flags)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Edge counter used to measure accept-to-valid latency.
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Consumer readiness: always ready, stalled, or randomly toggling.
   always @(posedge clk) begin
      #1;
      case (readyMode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic expT mkExp(input logic [63:0] q, input logic [3:0] f, input int lat);
      expT e;
      e.q   = q;
      e.f   = f;
      e.lat = lat;
      e.acc = 0;
      return e;
   endfunction

   // Reference: classify operands, otherwise divide exact integer
   // significands and round the wide quotient to 53 bits, nearest-even.
   function automatic expT refDiv(input logic [63:0] a, input logic [63:0] b);
      expT          r;
      logic         signA, signB, s;
      int           ea, eb, e, shift;
      logic [51:0]  fa, fb;
      bit           aZero, bZero, aInf, bInf, aNan, bNan, sticky, up;
      logic [127:0] num, den, quo, mant, low, half;
      signA = a[63];
      signB = b[63];
      ea    = int'(a[62:52]);
      eb    = int'(b[62:52]);
      fa    = a[51:0];
      fb    = b[51:0];
      s     = signA ^ signB;
      aZero = (ea == 0);
      bZero = (eb == 0);
      aInf  = (ea == 2047) && (fa == 0);
      bInf  = (eb == 2047) && (fb == 0);
      aNan  = (ea == 2047) && (fa != 0);
      bNan  = (eb == 2047) && (fb != 0);
      r     = mkExp(64'd0, 4'b0000, LAT_SPECIAL);
      if (aNan || bNan) begin
         r.q = 64'h7FF8000000000000;
      end else if ((aZero && bZero) || (aInf && bInf)) begin
         r.q = 64'h7FF8000000000000;
         r.f = 4'b1000;
      end else if (aInf) begin
         r.q = {s, 11'h7FF, 52'd0};
      end else if (bZero) begin
         r.q = {s, 11'h7FF, 52'd0};
         r.f = 4'b0100;
      end else if (bInf || aZero) begin
         r.q = {s, 63'd0};
      end else begin
         r.lat  = LAT_NORMAL;
         num    = {75'd0, 1'b1, fa} << 60;
         den    = {75'd0, 1'b1, fb};
         quo    = num / den;
         sticky = (num % den) != 0;
         e      = ea - eb + 1023;
         if (quo >= (128'd1 << 60)) begin
            shift = 8;
         end else begin
            shift = 7;
            e     = e - 1;
         end
         mant = quo >> shift;
         low  = quo & ((128'd1 << shift) - 128'd1);
         half = 128'd1 << (shift - 1);
         up   = (low > half) || ((low == half) && (sticky || mant[0]));
         if (up) mant = mant + 128'd1;
         if (mant == (128'd1 << 53)) begin
            mant = mant >> 1;
            e    = e + 1;
         end
         if (e >= 2047) begin
            r.q = {s, 11'h7FF, 52'd0};
            r.f = 4'b0010;
         end else if (e <= 0) begin
            r.q = {s, 63'd0};
            r.f = 4'b0001;
         end else begin
            r.q = {s, 11'(e), mant[51:0]};
         end
      end
      return r;
   endfunction

   function automatic logic [63:0] randOperand();
      int          k;
      logic        s;
      logic [63:0] rnd;
      logic [51:0] fr;
      logic [10:0] ex;
      k   = $urandom_range(0, 19);
      s   = 1'($urandom_range(0, 1));
      rnd = {$urandom, $urandom};
      fr  = rnd[51:0];
      case (k)
         0:       ex = 11'd0;
         1:       ex = 11'h7FF;
         2:       ex = 11'h7FF;
         3:       ex = 11'd0;
         4:       ex = 11'($urandom_range(1990, 2046));
         5:       ex = 11'($urandom_range(1, 60));
         default: ex = 11'($urandom_range(823, 1223));
      endcase
      if (k == 0 || k == 1) fr = 52'd0;
      if (k == 2 || k == 3) fr = fr | 52'd1;
      return {s, ex, fr};
   endfunction

   // Present operands until accepted, then record the expected response.
   task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input expT e);
      int  waitCnt;
      bit  accepted;
      expT ent;
      ent      = e;
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      accepted = 0;
      waitCnt  = 0;
      while (!accepted && waitCnt < 400) begin
         @(negedge clk);
         if (in_ready && !rset) begin
            ent.acc = cycleCnt + 1;
            scoreQ.push_back(ent);
            accepted = 1;
         end
         @(posedge clk);
         #1;
         waitCnt++;
      end
      in_valid = 1'b0;
      dividend = {$urandom, $urandom};
      divisor  = {$urandom, $urandom};
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1 within 400 cycles");
      end
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((scoreQ.size() != 0 || out_valid) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("drain_pending", 64'(scoreQ.size()), 64'd0);
   endtask

   // Monitor: compare each presented result with the scoreboard head,
   // check it stays stable while stalled, and retire it on handshake.
   always @(negedge clk) begin
      if (!rset && out_valid) begin
         if (!holding) begin
            holding = 1'b1;
            heldQ   = quotient;
            heldF   = flags;
            if (scoreQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_output: got %h flags %b, expected no output", quotient, flags);
            end else begin
               checkOutput("quotient", quotient, scoreQ[0].q);
               checkOutput("flags", 64'(flags), 64'(scoreQ[0].f));
               checkOutput("latency", 64'(cycleCnt - scoreQ[0].acc), 64'(scoreQ[0].lat));
            end
         end else begin
            checkOutput("hold_quotient", quotient, heldQ);
            checkOutput("hold_flags", 64'(flags), 64'(heldF));
         end
         if (out_ready) begin
            holding = 1'b0;
            if (scoreQ.size() > 0) void'(scoreQ.pop_front());
         end
      end
   end

   initial begin
      dirA = '{64'h4018000000000000, 64'h3FF0000000000000, 64'hBFF0000000000000,
               64'h3FF0000000000000, 64'h0000000000000000, 64'h8000000000000000,
               64'h7FEFFFFFFFFFFFFF, 64'h0010000000000000, 64'hFFF0000000000000,
               64'h7FF0000000000001, 64'h0000000000000001, 64'hC000000000000000,
               64'hFFF0000000000000};
      dirB = '{64'h4000000000000000, 64'h4008000000000000, 64'h4008000000000000,
               64'h0000000000000000, 64'h0000000000000000, 64'h4014000000000000,
               64'h3FE0000000000000, 64'h4000000000000000, 64'h7FF0000000000000,
               64'hBFF0000000000000, 64'hC000000000000000, 64'hFFF0000000000000,
               64'h4000000000000000};
      dirQ = '{64'h4008000000000000, 64'h3FD5555555555555, 64'hBFD5555555555555,
               64'h7FF0000000000000, 64'h7FF8000000000000, 64'h8000000000000000,
               64'h7FF0000000000000, 64'h0000000000000000, 64'h7FF8000000000000,
               64'h7FF8000000000000, 64'h8000000000000000, 64'h0000000000000000,
               64'hFFF0000000000000};
      dirF = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0010,
               4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      dirL = '{LAT_NORMAL, LAT_NORMAL, LAT_NORMAL, LAT_SPECIAL, LAT_SPECIAL,
               LAT_SPECIAL, LAT_NORMAL, LAT_NORMAL, LAT_SPECIAL, LAT_SPECIAL,
               LAT_SPECIAL, LAT_SPECIAL, LAT_SPECIAL};

      // Reset state
      #1;
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_quotient", quotient, 64'd0);
      checkOutput("reset_flags", 64'(flags), 64'd0);
      checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rset = 1'b0;
      #1;
      checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);

      // Directed operands with hand-derived expectations
      for (int i = 0; i < NUM_DIR; i++) begin
         applyStimulus(dirA[i], dirB[i], mkExp(dirQ[i], dirF[i], dirL[i]));
      end
      waitDrain();

      // Random operands against the reference model, random back-pressure
      readyMode = 2;
      for (int i = 0; i < NUM_RAND; i++) begin
         logic [63:0] a, b;
         a = randOperand();
         b = randOperand();
         applyStimulus(a, b, refDiv(a, b));
      end
      readyMode = 0;
      waitDrain();

      // Long stall: result held, no new operand accepted meanwhile
      readyMode = 1;
      @(posedge clk);
      #2;
      applyStimulus(64'h4018000000000000, 64'h4000000000000000,
                    mkExp(64'h4008000000000000, 4'b0000, LAT_NORMAL));
      begin
         int n;
         n = 0;
         while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
         end
      end
      checkOutput("bp_valid_seen", 64'(out_valid), 64'd1);
      for (int i = 0; i < 20; i++) begin
         checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
         checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
         in_valid = 1'b1;
         dividend = 64'h3FF0000000000000;
         divisor  = 64'h3FF0000000000000;
         @(negedge clk);
      end
      in_valid  = 1'b0;
      readyMode = 0;
      waitDrain();
      repeat (70) @(posedge clk);
      #1;
      checkOutput("bp_no_extra_output", 64'(out_valid), 64'd0);

      // Reset while a division is in progress
      applyStimulus(64'h4018000000000000, 64'h4000000000000000,
                    mkExp(64'h4008000000000000, 4'b0000, LAT_NORMAL));
      repeat (20) @(posedge clk);
      #1;
      rset = 1'b1;
      scoreQ.delete();
      #1;
      checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("midrst_quotient", quotient, 64'd0);
      checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rset = 1'b0;
      #1;
      checkOutput("midrst_release_in_ready", 64'(in_ready), 64'd1);
      applyStimulus(64'h3FF0000000000000, 64'h4008000000000000,
                    mkExp(64'h3FD5555555555555, 4'b0000, LAT_NORMAL));
      waitDrain();
      repeat (5) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
